// File: rtl/contador_pkg.sv
// Shared definitions for the up/down counter: boundary-mode constants, the load
// clamp helper and the elaboration-time parameter legality check macro.
`ifndef CONTADOR_PKG_SV
`define CONTADOR_PKG_SV

// Expands to a generate block that stops elaboration on an illegal parameter set.
`define CONTADOR_CHECK_PARAMS(W, MN, MX, RV) \
  if ((W) < 1 || (W) > 16 || (MN) < 0 || (MN) >= (MX) || (MX) > (2**(W)) - 1 || \
      (RV) < (MN) || (RV) > (MX)) begin : g_illegal_params \
    $error("contador_ud_param: illegal WIDTH/MIN_VAL/MAX_VAL/RESET_VAL combination"); \
  end

package contador_pkg;

  localparam int WRAP_SAT  = 0;
  localparam int WRAP_ROLL = 1;

  // Wide enough for any legal WIDTH plus the overflow guard bit.
  localparam int CNT_EXT_W = 17;

  function automatic logic [CNT_EXT_W-1:0] clamp_range(
    input logic [CNT_EXT_W-1:0] value,
    input logic [CNT_EXT_W-1:0] min_v,
    input logic [CNT_EXT_W-1:0] max_v
  );
    if (value > max_v)
      return max_v;
    else if (value < min_v)
      return min_v;
    else
      return value;
  endfunction

endpackage

`endif

// File: rtl/contador_ud_param_edge_rise.sv
// One-bit rising-edge detector: pulse is high while d is high and was low at the
// previous clock edge; the history register clears on reset.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_prev_reg;

  always_ff @(posedge clk) begin
    if (reset)
      d_prev_reg <= 1'b0;
    else
      d_prev_reg <= d;
  end

  assign pulse = d & ~d_prev_reg;

endmodule

// File: rtl/contador_ud_param.sv
// Parametrised up/down counter over [MIN_VAL, MAX_VAL] with saturate or wrap bounds,
// parallel load and wrap pulse. Define CONTADOR_UD_EDGE_EN for edge-triggered up/down.
module contador_ud_param
  import contador_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 7,
  parameter int WRAP      = 0,
  parameter int RESET_VAL = MIN_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrapped
);

  `CONTADOR_CHECK_PARAMS(WIDTH, MIN_VAL, MAX_VAL, RESET_VAL)

  // One extra bit keeps MAX_VAL + 1 representable when MAX_VAL = 2^WIDTH-1.
  localparam int            EW        = WIDTH + 1;
  localparam logic [EW-1:0] MIN_EXT   = EW'(MIN_VAL);
  localparam logic [EW-1:0] MAX_EXT   = EW'(MAX_VAL);
  localparam logic [EW-1:0] RESET_EXT = EW'(RESET_VAL);
  localparam logic [EW-1:0] ONE_EXT   = EW'(1);

  logic          up_q;
  logic          down_q;
  logic          inc;
  logic          dec;
  logic [EW-1:0] count_reg;
  logic [EW-1:0] count_next;
  logic          wrapped_reg;
  logic          wrapped_next;

`ifdef CONTADOR_UD_EDGE_EN
  edge_rise u_edge_up (
    .clk   (clk),
    .reset (reset),
    .d     (up),
    .pulse (up_q)
  );

  edge_rise u_edge_down (
    .clk   (clk),
    .reset (reset),
    .d     (down),
    .pulse (down_q)
  );
`else
  assign up_q   = up;
  assign down_q = down;
`endif

  assign inc = en & up_q & ~down_q;
  assign dec = en & down_q & ~up_q;

  always_comb begin
    count_next   = count_reg;
    wrapped_next = 1'b0;
    if (load) begin
      count_next = EW'(clamp_range(CNT_EXT_W'(load_val), CNT_EXT_W'(MIN_VAL),
                                   CNT_EXT_W'(MAX_VAL)));
    end else if (inc) begin
      if (count_reg < MAX_EXT) begin
        count_next = count_reg + ONE_EXT;
      end else if (WRAP == WRAP_ROLL) begin
        count_next   = MIN_EXT;
        wrapped_next = 1'b1;
      end
    end else if (dec) begin
      if (count_reg > MIN_EXT) begin
        count_next = count_reg - ONE_EXT;
      end else if (WRAP == WRAP_ROLL) begin
        count_next   = MAX_EXT;
        wrapped_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= RESET_EXT;
      wrapped_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign count   = count_reg[WIDTH-1:0];
  assign at_max  = (count_reg == MAX_EXT);
  assign at_min  = (count_reg == MIN_EXT);
  assign wrapped = wrapped_reg;

endmodule

// File: tb/tb_contador_ud_param.sv
// Directed bench for contador_ud_param: three instances (saturate 0..7, wrap 0..7,
// saturate 2..5) share one stimulus stream; expected values are hand-computed.
`timescale 1ns/1ps
module tb_contador_ud_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       down;
  logic       load;
  logic [2:0] load_val;

  logic [2:0] c_sat, c_wrp, c_rng;
  logic       mx_sat, mx_wrp, mx_rng;
  logic       mn_sat, mn_wrp, mn_rng;
  logic       w_sat, w_wrp, w_rng;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  contador_ud_param #(.WIDTH(3), .MIN_VAL(0), .MAX_VAL(7), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .down(down), .load(load),
    .load_val(load_val), .count(c_sat), .at_max(mx_sat), .at_min(mn_sat), .wrapped(w_sat)
  );

  contador_ud_param #(.WIDTH(3), .MIN_VAL(0), .MAX_VAL(7), .WRAP(1)) u_wrp (
    .clk(clk), .reset(reset), .en(en), .up(up), .down(down), .load(load),
    .load_val(load_val), .count(c_wrp), .at_max(mx_wrp), .at_min(mn_wrp), .wrapped(w_wrp)
  );

  contador_ud_param #(.WIDTH(3), .MIN_VAL(2), .MAX_VAL(5), .WRAP(0)) u_rng (
    .clk(clk), .reset(reset), .en(en), .up(up), .down(down), .load(load),
    .load_val(load_val), .count(c_rng), .at_max(mx_rng), .at_min(mn_rng), .wrapped(w_rng)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0; load_val = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #2;

    // Reset state
    do_reset();
    check("rst_sat_count", c_sat, 0);
    check("rst_sat_at_min", mn_sat, 1);
    check("rst_sat_at_max", mx_sat, 0);
    check("rst_sat_wrapped", w_sat, 0);
    check("rst_rng_count", c_rng, 2);
    check("rst_rng_at_min", mn_rng, 1);

`ifndef CONTADOR_UD_EDGE_EN
    // Level mode: up held 9 cycles
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("ramp%0d_sat_count", i), c_sat, (i > 7) ? 7 : i);
      check($sformatf("ramp%0d_sat_at_max", i), mx_sat, (i >= 7) ? 1 : 0);
      check($sformatf("ramp%0d_sat_wrapped", i), w_sat, 0);
      check($sformatf("ramp%0d_rng_count", i), c_rng, (i > 3) ? 5 : i + 2);
      if (i == 8) begin
        check("ramp8_wrp_count", c_wrp, 0);
        check("ramp8_wrp_wrapped", w_wrp, 1);
      end
      if (i == 9) begin
        check("ramp9_wrp_count", c_wrp, 1);
        check("ramp9_wrp_wrapped", w_wrp, 0);
      end
    end
`else
    // Edge mode: three long up pulses give exactly three steps
    en = 1'b1;
    for (int b = 0; b < 3; b++) begin
      up = 1'b1;
      repeat (10) tick();
      up = 1'b0;
      repeat (2) tick();
    end
    check("edge_sat_count", c_sat, 3);
    check("edge_rng_count", c_rng, 5);
    check("edge_wrp_count", c_wrp, 3);
`endif

    // Down at MIN: wrap to MAX vs saturate
    do_reset();
    en = 1'b1; down = 1'b1;
    tick();
    check("dn_wrp_count", c_wrp, 7);
    check("dn_wrp_wrapped", w_wrp, 1);
    check("dn_wrp_at_max", mx_wrp, 1);
    check("dn_sat_count", c_sat, 0);
    check("dn_rng_count", c_rng, 2);
    down = 1'b0;
    tick();
    check("dn_wrp_hold_count", c_wrp, 7);
    check("dn_wrp_pulse_end", w_wrp, 0);

    // Load clamps, ignores en
    idle_inputs();
    load = 1'b1; load_val = 3'd7;
    tick();
    check("ld7_rng_count", c_rng, 5);
    check("ld7_rng_at_max", mx_rng, 1);
    check("ld7_sat_count", c_sat, 7);
    load_val = 3'd0;
    tick();
    check("ld0_rng_count", c_rng, 2);
    check("ld0_rng_at_min", mn_rng, 1);
    check("ld0_sat_count", c_sat, 0);

    // Load has priority over a step and clears wrapped
    do_reset();
    en = 1'b1; down = 1'b1;
    tick();
    check("pre_ld_wrp_wrapped", w_wrp, 1);
    load = 1'b1; load_val = 3'd3;
    tick();
    check("ld_prio_wrp_count", c_wrp, 3);
    check("ld_prio_wrp_wrapped", w_wrp, 0);

    // up and down together hold; en=0 holds
    idle_inputs();
    load = 1'b1; load_val = 3'd4;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; down = 1'b1;
    repeat (3) tick();
    check("updn_sat_count", c_sat, 4);
    check("updn_wrp_count", c_wrp, 4);
    check("updn_rng_count", c_rng, 4);
    en = 1'b0; down = 1'b0;
    repeat (2) tick();
    check("en0_sat_count", c_sat, 4);
    check("en0_rng_count", c_rng, 4);

    // Reset overrides a would-be wrap, load and step
    idle_inputs();
    load = 1'b1; load_val = 3'd0;
    tick();
    load = 1'b0; en = 1'b1; down = 1'b1; reset = 1'b1;
    tick();
    check("rst_prio_wrp_count", c_wrp, 0);
    check("rst_prio_wrp_wrapped", w_wrp, 0);
    load = 1'b1; load_val = 3'd6; down = 1'b0; up = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_prio_sat_count", c_sat, 0);
    check("rst_prio_rng_count", c_rng, 2);

    // Synchronous reset: no effect between edges
    idle_inputs();
    load = 1'b1; load_val = 3'd5;
    tick();
    load = 1'b0;
    reset = 1'b1;
    #2;
    check("sync_rst_before_edge", c_sat, 5);
    tick();
    reset = 1'b0;
    check("sync_rst_after_edge", c_sat, 0);
    check("sync_rst_rng_after_edge", c_rng, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
